acc_seq_ctrl: RTL and testbench
===============================

# acc_seq_ctrl

Parametrised multi-cycle instruction sequencer for the accumulator CPU. It sits between the instruction register and the datapath (PC, register file, ACC, ALU). It steps every instruction through FETCH → SETTLE → EXEC → WB and drives one-cycle control strobes. Unlike the first-generation controller, it has a configurable data width, register-address width and settle delay. It also adds a sticky HALT state, a guaranteed PC advance on every non-taken instruction, and a defined response to unused opcodes.

## Interface
Parameters:
- DATA_W, 8, instruction/immediate width; opcode is instr[DATA_W-1 -: 4], operand is instr[DATA_W-5:0]; DATA_W ≥ 8
- REG_AW, 4, register-number width; REG_AW ≤ DATA_W-4
- SETTLE_CYCLES, 4, wait cycles between FETCH and EXEC; 0 allowed

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instr  in  DATA_W  current IR contents
- zero  in  1  ACC zero flag
- carry  in  1  ALU carry flag
- load_ir, inc_pc, sel_pc, load_pc, load_reg, dump_reg, load_acc, dump_acc  out  1 each  datapath strobes
- sel_acc  out  2  ACC input mux: 00 immediate, 01 register, 10 ALU
- sel_alu  out  4  ALU op: 0000 add, 0001 sub, 1000 nor, 1100 shr, 1101 shl
- imm_data  out  DATA_W  zero-extended operand
- reg_num  out  REG_AW  operand[REG_AW-1:0]
- halted  out  1  high while in HALT
- illegal  out  1  sticky unused-opcode flag (CTRL_ILLEGAL_TRAP_EN only; tied 0 otherwise)

## Operation
- States: FETCH, SETTLE, EXEC, WB, HALT.
- Transitions:
  - FETCH → SETTLE, or → EXEC if SETTLE_CYCLES = 0.
  - SETTLE → EXEC when the counter expires.
  - EXEC → WB.
  - WB → FETCH, or → HALT if the decoded opcode was F.
  - HALT → HALT until reset.
- FETCH: load_ir=1, all other strobes 0. The settle counter loads SETTLE_CYCLES-1.
- SETTLE, WB, HALT: all strobes 0.
- EXEC: strobes are driven for exactly one cycle, according to the opcode:
  - 0 NOP: inc_pc
  - 1 ADD / 2 SUB / 3 NOR: dump_reg, load_acc, sel_acc=10, sel_alu as above, reg_num, inc_pc
  - 4 LDR: dump_reg, load_acc, sel_acc=01, reg_num, inc_pc
  - 5 STR: dump_acc, load_reg, reg_num, inc_pc
  - D LDI: load_acc, sel_acc=00, imm_data, inc_pc
  - B SHL / C SHR: load_acc, sel_acc=10, sel_alu 1101/1100, inc_pc
  - 6 JZR / 8 JCR: if the flag is set, load_pc, sel_pc=0, dump_reg, reg_num; otherwise inc_pc
  - 7 JZI / A JCI: if the flag is set, load_pc, sel_pc=1, imm_data; otherwise inc_pc
  - F HLT: no strobes
  - 9, E: treated as NOP (see Configuration)
- inc_pc and load_pc are never high together.
- imm_data, reg_num, sel_acc and sel_alu hold their last EXEC value until the next EXEC.

## Timing
- All outputs are registered; each takes its value in the cycle it names a state for.
- instr, zero and carry are sampled at the edge that enters EXEC. Changes during SETTLE are ignored until that edge.
- Instruction period: SETTLE_CYCLES+3 cycles (7 at the defaults). Period 3 when SETTLE_CYCLES=0.
- Reset value: state FETCH at the first post-reset edge. All strobes, sel_acc, sel_alu, imm_data, reg_num, halted and illegal are 0.
- Reset asserted in any state, including HALT or mid-SETTLE, returns to the reset values on the next edge. The strobes of an aborted EXEC are not completed.
- halted rises in the cycle after WB of HLT.
- Counter width: $clog2(SETTLE_CYCLES+1), minimum 1.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: opcodes 9 and E issue no strobes in EXEC. illegal sets in WB and is sticky until reset, and the FSM enters HALT.
- CTRL_ILLEGAL_TRAP_EN undefined: opcodes 9 and E execute as NOP (inc_pc only), and illegal is tied 0.

## Structure
- Shared package acc_cpu_pkg holds:
  - the opcode enum (4 bits)
  - the state enum
  - the sel_acc constants (SEL_IMM, SEL_REG, SEL_ALU)
  - the ALU op codes
- Sub-module acc_seq_decode: combinational opcode+flags → strobe bundle, instantiated once and registered in EXEC. The FSM and settle counter stay in the top level.

## Test plan
- Reset, then LDI 0xD5 (defaults) → load_ir at cycle 0; load_acc=1, sel_acc=00, imm_data=0x05, inc_pc=1 at cycle 5; WB at cycle 6; FETCH again at cycle 7.
- ADD 0x13 → sel_alu=0000, sel_acc=10, reg_num=3, dump_reg=1, load_acc=1, inc_pc=1 in EXEC only.
- JZI 0x7A with zero=1 → load_pc=1, sel_pc=1, imm_data=0x0A, inc_pc=0. The same instruction with zero=0 → inc_pc=1 only. Toggling zero during SETTLE has no effect; only the value at EXEC entry counts.
- HLT 0xF0 → halted=1 after WB and no further load_ir for 20 cycles. A reset pulse restarts in FETCH.
- Opcode 0x90 → with the macro: illegal=1, halted=1, no strobes. Without the macro: inc_pc=1, illegal=0.
- SETTLE_CYCLES=0 build, with reset asserted mid-SETTLE at default → period 3 (strobes at cycle 1); the mid-SETTLE reset gives all outputs 0 and FETCH on the next edge.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared types and constants for the accumulator CPU control path:
// opcodes, sequencer states, ACC input-mux selects, ALU op codes and the decoded strobe bundle.
package acc_cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_NOR  = 4'h3,
      OP_LDR  = 4'h4,
      OP_STR  = 4'h5,
      OP_JZR  = 4'h6,
      OP_JZI  = 4'h7,
      OP_JCR  = 4'h8,
      OP_RSV9 = 4'h9,
      OP_JCI  = 4'hA,
      OP_SHL  = 4'hB,
      OP_SHR  = 4'hC,
      OP_LDI  = 4'hD,
      OP_RSVE = 4'hE,
      OP_HLT  = 4'hF
   } opcode_t;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_SETTLE,
      ST_EXEC,
      ST_WB,
      ST_HALT
   } state_t;

   localparam logic [1:0] SEL_IMM = 2'b00;
   localparam logic [1:0] SEL_REG = 2'b01;
   localparam logic [1:0] SEL_ALU = 2'b10;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_NOR = 4'b1000;
   localparam logic [3:0] ALU_SHR = 4'b1100;
   localparam logic [3:0] ALU_SHL = 4'b1101;

   typedef struct packed {
      logic       inc_pc;
      logic       sel_pc;
      logic       load_pc;
      logic       load_reg;
      logic       dump_reg;
      logic       load_acc;
      logic       dump_acc;
      logic [1:0] sel_acc;
      logic [3:0] sel_alu;
      logic       halt;
      logic       trap;
   } ctrl_t;

endpackage

// File: rtl/acc_seq_decode.sv
// Combinational opcode + flag decode into the EXEC strobe bundle.
// CTRL_ILLEGAL_TRAP_EN: opcodes 9/E trap instead of executing as NOP.
module acc_seq_decode
   import acc_cpu_pkg::*;
(
   input  opcode_t opcode,
   input  logic    zero,
   input  logic    carry,
   output ctrl_t   ctrl
);

   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_ADD, OP_SUB, OP_NOR: begin
            ctrl.dump_reg = 1'b1;
            ctrl.load_acc = 1'b1;
            ctrl.sel_acc  = SEL_ALU;
            ctrl.sel_alu  = (opcode == OP_ADD) ? ALU_ADD :
                            (opcode == OP_SUB) ? ALU_SUB : ALU_NOR;
            ctrl.inc_pc   = 1'b1;
         end
         OP_LDR: begin
            ctrl.dump_reg = 1'b1;
            ctrl.load_acc = 1'b1;
            ctrl.sel_acc  = SEL_REG;
            ctrl.inc_pc   = 1'b1;
         end
         OP_STR: begin
            ctrl.dump_acc = 1'b1;
            ctrl.load_reg = 1'b1;
            ctrl.inc_pc   = 1'b1;
         end
         OP_LDI: begin
            ctrl.load_acc = 1'b1;
            ctrl.sel_acc  = SEL_IMM;
            ctrl.inc_pc   = 1'b1;
         end
         OP_SHL, OP_SHR: begin
            ctrl.load_acc = 1'b1;
            ctrl.sel_acc  = SEL_ALU;
            ctrl.sel_alu  = (opcode == OP_SHL) ? ALU_SHL : ALU_SHR;
            ctrl.inc_pc   = 1'b1;
         end
         OP_JZR, OP_JCR: begin
            // Register-indirect jump: PC loads from the register file, else fall through.
            if ((opcode == OP_JZR) ? zero : carry) begin
               ctrl.load_pc  = 1'b1;
               ctrl.dump_reg = 1'b1;
            end else begin
               ctrl.inc_pc = 1'b1;
            end
         end
         OP_JZI, OP_JCI: begin
            if ((opcode == OP_JZI) ? zero : carry) begin
               ctrl.load_pc = 1'b1;
               ctrl.sel_pc  = 1'b1;
            end else begin
               ctrl.inc_pc = 1'b1;
            end
         end
         OP_HLT: ctrl.halt = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
         OP_RSV9, OP_RSVE: ctrl.trap = 1'b1;
`endif
         default: ctrl.inc_pc = 1'b1;
      endcase
   end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Multi-cycle FETCH/SETTLE/EXEC/WB sequencer for the accumulator CPU with registered strobes.
// CTRL_ILLEGAL_TRAP_EN: unused opcodes set a sticky illegal flag and halt the sequencer.
module acc_seq_ctrl
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int REG_AW        = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] instr,
   input  logic              zero,
   input  logic              carry,
   output logic              load_ir,
   output logic              inc_pc,
   output logic              sel_pc,
   output logic              load_pc,
   output logic              load_reg,
   output logic              dump_reg,
   output logic              load_acc,
   output logic              dump_acc,
   output logic [1:0]        sel_acc,
   output logic [3:0]        sel_alu,
   output logic [DATA_W-1:0] imm_data,
   output logic [REG_AW-1:0] reg_num,
   output logic              halted,
   output logic              illegal
);

   localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             exec_halt;
   logic             exec_trap;
   logic             go_exec;
   ctrl_t            ctrl;

   acc_seq_decode u_decode (
      .opcode (opcode_t'(instr[DATA_W-1 -: 4])),
      .zero   (zero),
      .carry  (carry),
      .ctrl   (ctrl)
   );

   // A FETCH entered from reset carries no load_ir yet; it is issued on the following edge.
   always_comb begin
      go_exec = 1'b0;
      if (state == ST_FETCH && load_ir && SETTLE_CYCLES == 0)
         go_exec = 1'b1;
      else if (state == ST_SETTLE && cnt == '0)
         go_exec = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FETCH;
         cnt       <= '0;
         exec_halt <= 1'b0;
         exec_trap <= 1'b0;
         load_ir   <= 1'b0;
         inc_pc    <= 1'b0;
         sel_pc    <= 1'b0;
         load_pc   <= 1'b0;
         load_reg  <= 1'b0;
         dump_reg  <= 1'b0;
         load_acc  <= 1'b0;
         dump_acc  <= 1'b0;
         sel_acc   <= '0;
         sel_alu   <= '0;
         imm_data  <= '0;
         reg_num   <= '0;
         halted    <= 1'b0;
      end else begin
         load_ir  <= 1'b0;
         inc_pc   <= 1'b0;
         sel_pc   <= 1'b0;
         load_pc  <= 1'b0;
         load_reg <= 1'b0;
         dump_reg <= 1'b0;
         load_acc <= 1'b0;
         dump_acc <= 1'b0;
         case (state)
            ST_FETCH: begin
               if (!load_ir) begin
                  load_ir <= 1'b1;
               end else if (SETTLE_CYCLES != 0) begin
                  state <= ST_SETTLE;
                  cnt   <= CNT_LOAD;
               end
            end
            ST_SETTLE: cnt <= cnt - 1'b1;
            ST_EXEC:   state <= ST_WB;
            ST_WB: begin
               if (exec_halt || exec_trap) begin
                  state  <= ST_HALT;
                  halted <= 1'b1;
               end else begin
                  state   <= ST_FETCH;
                  load_ir <= 1'b1;
               end
            end
            default: state <= ST_HALT;
         endcase
         if (go_exec) begin
            state     <= ST_EXEC;
            exec_halt <= ctrl.halt;
            exec_trap <= ctrl.trap;
            inc_pc    <= ctrl.inc_pc;
            sel_pc    <= ctrl.sel_pc;
            load_pc   <= ctrl.load_pc;
            load_reg  <= ctrl.load_reg;
            dump_reg  <= ctrl.dump_reg;
            load_acc  <= ctrl.load_acc;
            dump_acc  <= ctrl.dump_acc;
            sel_acc   <= ctrl.sel_acc;
            sel_alu   <= ctrl.sel_alu;
            imm_data  <= {4'b0000, instr[DATA_W-5:0]};
            reg_num   <= instr[REG_AW-1:0];
         end
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk) begin
      if (reset)
         illegal_q <= 1'b0;
      else if (state == ST_EXEC && exec_trap)
         illegal_q <= 1'b1;
   end
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl: default build plus a SETTLE_CYCLES=0 instance.
module tb_acc_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset, reset_b;
   logic [7:0] instr, instr_b;
   logic       zero, carry;
   int         checks = 0;
   int         errors = 0;

   logic       load_ir, inc_pc, sel_pc, load_pc, load_reg, dump_reg, load_acc, dump_acc;
   logic [1:0] sel_acc;
   logic [3:0] sel_alu;
   logic [7:0] imm_data;
   logic [3:0] reg_num;
   logic       halted, illegal;

   logic       load_ir_b, inc_pc_b, sel_pc_b, load_pc_b, load_reg_b, dump_reg_b, load_acc_b, dump_acc_b;
   logic [1:0] sel_acc_b;
   logic [3:0] sel_alu_b;
   logic [7:0] imm_data_b;
   logic [3:0] reg_num_b;
   logic       halted_b, illegal_b;

   // Strobe vector order: load_ir inc_pc sel_pc load_pc load_reg dump_reg load_acc dump_acc
   wire [7:0] strb   = {load_ir, inc_pc, sel_pc, load_pc, load_reg, dump_reg, load_acc, dump_acc};
   wire [7:0] strb_b = {load_ir_b, inc_pc_b, sel_pc_b, load_pc_b, load_reg_b, dump_reg_b, load_acc_b, dump_acc_b};

   always #5 clk = ~clk;

   acc_seq_ctrl dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero), .carry(carry),
      .load_ir(load_ir), .inc_pc(inc_pc), .sel_pc(sel_pc), .load_pc(load_pc),
      .load_reg(load_reg), .dump_reg(dump_reg), .load_acc(load_acc), .dump_acc(dump_acc),
      .sel_acc(sel_acc), .sel_alu(sel_alu), .imm_data(imm_data), .reg_num(reg_num),
      .halted(halted), .illegal(illegal)
   );

   acc_seq_ctrl #(.DATA_W(8), .REG_AW(4), .SETTLE_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset_b), .instr(instr_b), .zero(zero), .carry(carry),
      .load_ir(load_ir_b), .inc_pc(inc_pc_b), .sel_pc(sel_pc_b), .load_pc(load_pc_b),
      .load_reg(load_reg_b), .dump_reg(dump_reg_b), .load_acc(load_acc_b), .dump_acc(dump_acc_b),
      .sel_acc(sel_acc_b), .sel_alu(sel_alu_b), .imm_data(imm_data_b), .reg_num(reg_num_b),
      .halted(halted_b), .illegal(illegal_b)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int fetches;

   initial begin
      reset = 1'b1; reset_b = 1'b1;
      instr = 8'hD5; instr_b = 8'hD3;
      zero = 1'b0; carry = 1'b0;
      step(2);
      chk("rst_strobes", strb, 8'h00);
      chk("rst_sel", {sel_acc, sel_alu}, 6'h00);
      chk("rst_data", {imm_data, reg_num}, 12'h000);
      chk("rst_flags", {halted, illegal}, 2'b00);

      // LDI 0xD5: FETCH at cycle 0, EXEC at cycle 5, WB at 6, FETCH at 7
      reset = 1'b0;
      step(1);
      chk("ldi_c0_fetch", strb, 8'h80);
      step(4);
      chk("ldi_c4_settle", strb, 8'h00);
      step(1);
      chk("ldi_exec_strb", strb, 8'h42);
      chk("ldi_exec_sel_acc", sel_acc, 2'b00);
      chk("ldi_exec_imm", imm_data, 8'h05);
      step(1);
      chk("ldi_wb_strb", strb, 8'h00);
      step(1);
      chk("ldi_c7_fetch", strb, 8'h80);

      // ADD 0x13
      instr = 8'h13;
      step(5);
      chk("add_exec_strb", strb, 8'h46);
      chk("add_exec_sel", {sel_acc, sel_alu}, {2'b10, 4'b0000});
      chk("add_exec_reg", reg_num, 4'h3);
      step(1);
      chk("add_wb_strb", strb, 8'h00);
      chk("add_wb_hold", {sel_acc, reg_num}, {2'b10, 4'h3});
      step(1);

      // STR 0x57
      instr = 8'h57;
      step(5);
      chk("str_exec_strb", strb, 8'h49);
      chk("str_exec_reg", reg_num, 4'h7);
      step(2);

      // JZI 0x7A, zero toggles in SETTLE but is 1 at EXEC entry
      instr = 8'h7A;
      step(2); zero = 1'b1;
      step(1); zero = 1'b0;
      step(1); zero = 1'b1;
      step(1);
      chk("jzi_taken_strb", strb, 8'h30);
      chk("jzi_taken_imm", imm_data, 8'h0A);
      step(2);

      // JZI 0x7A, zero high in SETTLE but 0 at EXEC entry
      step(1); zero = 1'b1;
      step(2); zero = 1'b0;
      step(2);
      chk("jzi_not_taken_strb", strb, 8'h40);
      step(2);

      // JCR 0x82 with carry=1
      instr = 8'h82; carry = 1'b1;
      step(5);
      chk("jcr_taken_strb", strb, 8'h14);
      chk("jcr_taken_reg", reg_num, 4'h2);
      carry = 1'b0;
      step(2);

      // HLT 0xF0
      instr = 8'hF0;
      step(5);
      chk("hlt_exec_strb", strb, 8'h00);
      step(1);
      chk("hlt_wb_halted", halted, 1'b0);
      step(1);
      chk("hlt_halted", halted, 1'b1);
      fetches = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (load_ir) fetches++;
      end
      chk("hlt_no_fetch", fetches, 0);
      chk("hlt_still_halted", halted, 1'b1);
      reset = 1'b1;
      step(1);
      chk("hlt_rst_flags", {halted, strb}, 9'h000);
      reset = 1'b0;
      step(1);
      chk("hlt_restart_fetch", strb, 8'h80);

      // Unused opcode 0x90
      instr = 8'h90;
      step(5);
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk("op9_exec_strb", strb, 8'h00);
      step(1);
      chk("op9_wb_illegal", illegal, 1'b1);
      step(1);
      chk("op9_halt", {halted, illegal, strb}, {2'b11, 8'h00});
`else
      chk("op9_exec_strb", strb, 8'h40);
      step(1);
      chk("op9_wb_illegal", illegal, 1'b0);
      step(1);
      chk("op9_next_fetch", {halted, illegal, strb}, {2'b00, 8'h80});
`endif

      // Mid-SETTLE reset after a fresh LDI fetch
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      instr = 8'hD5;
      step(1);
      chk("mid_fetch", strb, 8'h80);
      step(2);
      reset = 1'b1;
      step(1);
      chk("mid_rst_strobes", strb, 8'h00);
      chk("mid_rst_all", {sel_acc, sel_alu, imm_data, reg_num, halted, illegal}, 24'h0);
      reset = 1'b0;
      step(1);
      chk("mid_rst_refetch", strb, 8'h80);
      step(4);
      chk("mid_rst_no_early_exec", strb, 8'h00);

      // SETTLE_CYCLES=0 instance: period 3
      reset_b = 1'b0;
      step(1);
      chk("b_c0_fetch", strb_b, 8'h80);
      step(1);
      chk("b_c1_exec", strb_b, 8'h42);
      chk("b_c1_imm", imm_data_b, 8'h03);
      step(1);
      chk("b_c2_wb", strb_b, 8'h00);
      step(1);
      chk("b_c3_fetch", strb_b, 8'h80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
